// File: rtl/pipe_add_pkg.sv
// Shared constants and configuration check for the pipelined carry adder.
package pipe_add_pkg;

  localparam int PIPE_ADD_WIDTH_DEF  = 16;
  localparam int PIPE_ADD_STAGES_DEF = 4;

  function automatic bit pipe_add_cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// One pipeline slice: CHUNK-bit ripple of full adders feeding this slice's register bank.
module pipe_add_stage
  import pipe_add_pkg::*;
#(
  parameter int WIDTH = PIPE_ADD_WIDTH_DEF,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_in,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             valid_out,
  output logic             carry_out,
  output logic             ovf_next,
  output logic [WIDTH-1:0] sum_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);

  localparam int LO = IDX * CHUNK;
  localparam int HI = LO + CHUNK;
  // Operand bits still waiting to be added by later slices.
  localparam logic [WIDTH-1:0] UPPER_MASK = {WIDTH{1'b1}} << HI;

  logic [CHUNK:0]   c;
  logic [CHUNK-1:0] s;
  logic [WIDTH-1:0] sum_next;

  logic             valid_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  assign c[0] = carry_in;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign s[gi]   = a_in[LO+gi] ^ b_in[LO+gi] ^ c[gi];
    assign c[gi+1] = (a_in[LO+gi] & b_in[LO+gi]) | (c[gi] & (a_in[LO+gi] ^ b_in[LO+gi]));
  end

  // Only meaningful in the top slice, where c[CHUNK-1] is the carry into the MSB.
  assign ovf_next = c[CHUNK] ^ c[CHUNK-1];

  always_comb begin
    sum_next            = sum_in;
    sum_next[LO +: CHUNK] = s;
  end

  // Data is captured only with a live beat so idle cycles leave the outputs untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else if (en) begin
      valid_reg <= valid_in;
      if (valid_in) begin
        carry_reg <= c[CHUNK];
        sum_reg   <= sum_next;
        a_reg     <= a_in & UPPER_MASK;
        b_reg     <= b_in & UPPER_MASK;
      end
    end
  end

  assign valid_out = valid_reg;
  assign carry_out = carry_reg;
  assign sum_out   = sum_reg;
  assign a_out     = a_reg;
  assign b_out     = b_reg;

endmodule

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit adder split into STAGES registered carry slices with global-stall valid/ready.
// Define PIPE_ADD_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_carry_adder
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = PIPE_ADD_WIDTH_DEF,
  parameter int STAGES = PIPE_ADD_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!pipe_add_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_carry_adder: STAGES must be 1..WIDTH and divide WIDTH");
  end

  logic                en;
  logic                in_xfer;
  logic [STAGES-1:0]   valid_s;
  logic [STAGES-1:0]   carry_s;
  logic [STAGES-1:0]   vin_s;
  logic [STAGES-1:0]   ovf_nxt;
  logic [WIDTH-1:0]    sum_s [STAGES];
  logic [WIDTH-1:0]    a_s   [STAGES];
  logic [WIDTH-1:0]    b_s   [STAGES];

  // Stall only when a finished result is being refused; empty slots never collapse.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign in_xfer  = in_valid && in_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic             carry_i;
    logic [WIDTH-1:0] sum_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;

    if (gi == 0) begin : g_first
      assign vin_s[gi] = in_xfer;
      assign carry_i   = cin;
      assign sum_i     = '0;
      assign a_i       = a;
      assign b_i       = b;
    end else begin : g_chain
      assign vin_s[gi] = valid_s[gi-1];
      assign carry_i   = carry_s[gi-1];
      assign sum_i     = sum_s[gi-1];
      assign a_i       = a_s[gi-1];
      assign b_i       = b_s[gi-1];
    end

    pipe_add_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (gi)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .valid_in  (vin_s[gi]),
      .carry_in  (carry_i),
      .sum_in    (sum_i),
      .a_in      (a_i),
      .b_in      (b_i),
      .valid_out (valid_s[gi]),
      .carry_out (carry_s[gi]),
      .ovf_next  (ovf_nxt[gi]),
      .sum_out   (sum_s[gi]),
      .a_out     (a_s[gi]),
      .b_out     (b_s[gi])
    );
  end

  assign out_valid = valid_s[STAGES-1];
  assign sum       = sum_s[STAGES-1];
  assign cout      = carry_s[STAGES-1];

  // The last slice has no operands left to forward.
  logic unused_tail;
  assign unused_tail = ^{a_s[STAGES-1], b_s[STAGES-1], ovf_nxt};

`ifdef PIPE_ADD_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (en && vin_s[STAGES-1]) begin
      ovf_reg <= ovf_nxt[STAGES-1];
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Randomised and directed checks of pipelined_carry_adder against an arithmetic scoreboard.
module tb_pipelined_carry_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PIPE_ADD_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q [$];
  logic [17:0] sb_e;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_word  = '0;
  logic [16:0] held_word;
  logic [17:0] r;

  always #5 clk = ~clk;

  pipelined_carry_adder #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic ci);
    int unsigned full;
    int          ssum;
    logic        sv;
    full = int'(x) + int'(y) + int'(ci);
    ssum = int'($signed(x)) + int'($signed(y)) + int'(ci);
    sv   = (ssum > 32767) || (ssum < -32768);
    return {sv, full[16:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: the handshake seen at a negedge is what transfers at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check_val("stall_stable", {15'd0, cout, sum}, {15'd0, prev_word});
      prev_stall = out_valid && !out_ready;
      prev_word  = {cout, sum};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("sb_unexpected_beat", 32'd1, 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          check_val("sb_sum", {16'd0, sum}, {16'd0, sb_e[15:0]});
          check_val("sb_cout", {31'd0, cout}, {31'd0, sb_e[16]});
`ifdef PIPE_ADD_OVF_EN
          check_val("sb_ovf", {31'd0, ovf}, {31'd0, sb_e[17]});
`endif
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_add(a, b, cin));
    end
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_sum", {16'd0, sum}, 32'd0);
    check_val("rst_cout", {31'd0, cout}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef PIPE_ADD_OVF_EN
    check_val("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check_val("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("idle_sum", {16'd0, sum}, 32'd0);

    // Full carry chain through every slice.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = '0; b = '0;
    for (int k = 1; k < S; k++) begin
      check_val("chain_wait", {31'd0, out_valid}, 32'd0);
      step();
    end
    check_val("chain_valid", {31'd0, out_valid}, 32'd1);
    check_val("chain_sum", {16'd0, sum}, 32'h0000);
    check_val("chain_cout", {31'd0, cout}, 32'd1);
    step();
    check_val("chain_once", {31'd0, out_valid}, 32'd0);

    // Streaming: 8 back-to-back beats, results consecutive from edge S-1.
    for (int j = 0; j < 8 + S; j++) begin
      if (j < 8) begin
        in_valid = 1'b1; a = 16'(j); b = 16'(16'h1000 * j); cin = j[0];
      end else begin
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
      end
      step();
      check_val("stream_valid", {31'd0, out_valid}, {31'd0, (j >= S - 1) && (j < S - 1 + 8)});
      if ((j >= S - 1) && (j < S - 1 + 8)) begin
        r = ref_add(16'(j - S + 1), 16'(16'h1000 * (j - S + 1)), 1'(j - S + 1));
        check_val("stream_sum", {16'd0, sum}, {16'd0, r[15:0]});
      end
    end

    // Signed overflow corners.
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 16'h8000; b = 16'h8000;
    step();
    in_valid = 1'b0; a = '0; b = '0;
    for (int k = 2; k < S; k++) step();
    check_val("ovf1_sum", {16'd0, sum}, 32'h8000);
    check_val("ovf1_cout", {31'd0, cout}, 32'd0);
`ifdef PIPE_ADD_OVF_EN
    check_val("ovf1_ovf", {31'd0, ovf}, 32'd1);
`endif
    step();
    check_val("ovf2_sum", {16'd0, sum}, 32'h0000);
    check_val("ovf2_cout", {31'd0, cout}, 32'd1);
`ifdef PIPE_ADD_OVF_EN
    check_val("ovf2_ovf", {31'd0, ovf}, 32'd1);
`endif
    for (int k = 0; k < S; k++) step();

    // Backpressure on a full pipeline.
    for (int k = 0; k < S; k++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      step();
    end
    check_val("bp_full", {31'd0, out_valid}, 32'd1);
    held_word = {cout, sum};
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b0; a = 16'($urandom); b = 16'($urandom);
      #1;
      check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("bp_hold", {15'd0, cout, sum}, {15'd0, held_word});
      step();
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_resume", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    for (int t = 0; t < 50 && exp_q.size() > 0; t++) step();
    check_val("bp_drain", exp_q.size(), 32'd0);

    // Randomised traffic with random backpressure.
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() > 0; t++) step();
    check_val("rand_drain", exp_q.size(), 32'd0);

    // Reset in the middle of traffic.
    for (int k = 0; k < S + 1; k++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      step();
    end
    check_val("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_sum", {16'd0, sum}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check_val("mid_no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_adder.md
# pipelined_carry_adder

Parametrised, pipelined two's-complement adder. It splits a WIDTH-bit addition into STAGES equal chunks with a registered carry between chunks, so the critical path is one CHUNK-bit ripple instead of a full-width ripple. It accepts one operation per cycle over a valid/ready handshake and applies global backpressure. It replaces the fixed 16-bit combinational ripple adder wherever the adder sits on a clocked datapath.

## Interface
- WIDTH, 16, operand and sum width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline register stages; range 1..WIDTH.
- CHUNK, WIDTH/STAGES, derived localparam (not overridable): bits added per stage.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow. Present only with PIPE_ADD_OVF_EN.

## Operation
- Stage k (k = 0..STAGES-1) adds chunk k of a and b plus the carry registered by stage k-1; stage 0 uses cin.
- Each stage has one register bank:
  - valid bit
  - carry
  - result chunks 0..k (lower chunks delayed for alignment)
  - raw operand chunks k+1..STAGES-1 (upper chunks carried forward unadded)
- The last stage register drives sum, cout and out_valid directly. There is no output logic after it.
- Global stall: en = !(out_valid && !out_ready). All stage registers load only when en is 1.
- in_ready = en. This is a combinational path from out_ready.
- Transfers:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Stage 0's valid loads the input transfer. Each later stage's valid loads the previous stage's valid.
- Bubbles are not collapsed. A stalled pipeline holds every stage, including empty ones.
- Results leave in acceptance order. Beats are never dropped or duplicated.
- Arithmetic is unsigned modulo 2^WIDTH, with cout = bit WIDTH of the full sum. Signed interpretation is the caller's concern except for ovf.
- While out_valid && !out_ready, sum, cout and ovf stay stable.
- Reset clears every valid bit, carry and data register to 0, so out_valid = 0, sum = 0, cout = 0 and ovf = 0. in_ready is then 1.
- Reset asserted mid-operation discards all in-flight beats. No stale result appears after release.

## Timing
- Latency: a beat accepted at edge t is visible on the outputs after edge t+STAGES-1. With STAGES=1 it is visible after edge t.
- Throughput is one beat per cycle when out_ready is held at 1.
- Stall:
  - out_ready low while out_valid is high drops in_ready in the same cycle.
  - The pipeline freezes at the next edge.
  - Flow resumes on the first edge where out_ready is 1.
- Simultaneous input and output transfers in one cycle are legal and the normal steady state.
- Critical path: CHUNK-bit ripple plus carry-register setup, plus the out_ready-to-in_ready path.

## Configuration
- PIPE_ADD_OVF_EN defined:
  - The ovf port exists.
  - The last stage computes ovf = carry into bit WIDTH-1 XOR cout.
  - ovf is registered with sum and resets to 0.
- PIPE_ADD_OVF_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Structure
- pipe_add_pkg holds:
  - default constants PIPE_ADD_WIDTH_DEF = 16 and PIPE_ADD_STAGES_DEF = 4
  - an elaboration-time check function that WIDTH % STAGES == 0
- Sub-module pipe_add_stage is instantiated STAGES times. It contains:
  - the CHUNK-bit ripple of full adders
  - the stage register bank, with enable and async reset
- The top level handles generate wiring, the enable/handshake logic and the optional ovf output.

## Test plan
All scenarios use WIDTH=16, STAGES=4.
- Reset: hold rst_n=0 -> out_valid=0, sum=16'h0000, cout=0, in_ready=1. Release -> outputs unchanged until a beat arrives.
- Full carry chain: a=16'hFFFF, b=16'h0001, cin=0 accepted at edge 0 -> after edge 3, sum=16'h0000, cout=1, out_valid=1 for exactly one cycle with out_ready=1.
- Streaming: 8 beats (a=i, b=16'h1000·i, cin=i[0]) on consecutive cycles with out_ready=1 -> 8 results on consecutive cycles from edge 3, in order, each matching the reference sum.
- Backpressure: pipeline full, out_ready=0 for 3 cycles -> in_ready=0 for those 3 cycles, sum/cout stable, then every beat delivered exactly once, in order.
- Overflow (PIPE_ADD_OVF_EN): a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1. a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, ovf=1.
- Reset mid-flight: 3 beats in flight, rst_n pulsed low for 1 cycle -> out_valid=0 immediately and no result appears within 6 cycles after release.
